// File: rtl/eth_phy_10g.sv
// 10GBASE-R PCS lite: 64b/66b encode/decode, block lock with bitslip, BER monitor.
// Optional scrambling via ETH_PHY_SCRAMBLER_EN (undefined: payload passes unscrambled).
module eth_phy_10g #(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int HDR_WIDTH           = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int COUNT_125US         = 125
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] xgmii_txd,
    input  logic [CTRL_WIDTH-1:0] xgmii_txc,
    output logic [DATA_WIDTH-1:0] xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] xgmii_rxc,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    input  logic [DATA_WIDTH-1:0] serdes_rx_data,
    input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    output logic                  serdes_rx_bitslip,
    output logic                  tx_bad_block,
    output logic                  rx_bad_block,
    output logic [6:0]            rx_error_count,
    output logic                  rx_block_lock,
    output logic                  rx_high_ber,
    output logic                  rx_status
);

    localparam logic [1:0]  SYNC_DATA = 2'b01;
    localparam logic [1:0]  SYNC_CTRL = 2'b10;
    localparam logic [7:0]  TYPE_CTRL = 8'h1E;
    localparam logic [55:0] CODES_ERR = {8{7'h1E}};
    localparam logic [63:0] BLK_IDLE  = {56'd0, TYPE_CTRL};
    localparam logic [63:0] BLK_ERR   = {CODES_ERR, TYPE_CTRL};
    localparam logic [63:0] XG_IDLE   = {8{8'h07}};
    localparam logic [63:0] XG_ERR    = {8{8'hFE}};

    localparam int SLIP_TOTAL = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
    localparam int SLIP_W     = $clog2(SLIP_TOTAL + 1);
    localparam int TIMER_W    = $clog2(COUNT_125US);
    localparam logic [SLIP_W-1:0]  SLIP_HIGH = SLIP_W'(BITSLIP_HIGH_CYCLES);
    localparam logic [SLIP_W-1:0]  SLIP_LAST = SLIP_W'(SLIP_TOTAL - 1);
    localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(COUNT_125US - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_SLIP,
        ST_LOCKED
    } state_t;

    // ---------------- TX encode ----------------
    logic [63:0] enc_data;
    logic [1:0]  enc_hdr;
    logic        enc_bad;
    logic [63:0] tx_payload;

    always_comb begin
        enc_hdr  = SYNC_CTRL;
        enc_data = BLK_ERR;
        enc_bad  = 1'b0;
        if (xgmii_txc == 8'h00) begin
            enc_hdr  = SYNC_DATA;
            enc_data = xgmii_txd;
        end else if (xgmii_txc == 8'hFF && xgmii_txd == XG_IDLE) begin
            enc_data = BLK_IDLE;
        end else if (!(xgmii_txc == 8'hFF && xgmii_txd == XG_ERR)) begin
            enc_bad = 1'b1;
        end
    end

`ifdef ETH_PHY_SCRAMBLER_EN
    logic [57:0] scr_state, scr_next, scr_s;
    logic [57:0] dsc_state, dsc_next, dsc_s;
    logic [63:0] scr_out, dsc_out;
    logic        scr_b;

    // Bit 0 goes on the wire first, so it is processed first.
    always_comb begin
        scr_out = '0;
        scr_s   = scr_state;
        scr_b   = 1'b0;
        for (int unsigned i = 0; i < 64; i++) begin
            scr_b      = enc_data[i] ^ scr_s[38] ^ scr_s[57];
            scr_out[i] = scr_b;
            scr_s      = {scr_s[56:0], scr_b};
        end
        scr_next = scr_s;
    end

    always_comb begin
        dsc_out = '0;
        dsc_s   = dsc_state;
        for (int unsigned i = 0; i < 64; i++) begin
            dsc_out[i] = serdes_rx_data[i] ^ dsc_s[38] ^ dsc_s[57];
            dsc_s      = {dsc_s[56:0], serdes_rx_data[i]};
        end
        dsc_next = dsc_s;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scr_state <= '1;
            dsc_state <= '1;
        end else begin
            scr_state <= scr_next;
            dsc_state <= dsc_next;
        end
    end

    assign tx_payload = scr_out;
    logic [63:0] rx_payload;
    assign rx_payload = dsc_out;
`else
    logic [63:0] rx_payload;
    assign tx_payload = enc_data;
    assign rx_payload = serdes_rx_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            serdes_tx_data <= '0;
            serdes_tx_hdr  <= SYNC_CTRL;
            tx_bad_block   <= 1'b0;
        end else begin
            serdes_tx_data <= tx_payload;
            serdes_tx_hdr  <= enc_hdr;
            tx_bad_block   <= enc_bad;
        end
    end

    // ---------------- RX decode ----------------
    logic        hdr_valid;
    logic [63:0] dec_rxd;
    logic [7:0]  dec_rxc;
    logic        dec_bad;

    assign hdr_valid = (serdes_rx_hdr == SYNC_DATA) || (serdes_rx_hdr == SYNC_CTRL);

    always_comb begin
        dec_rxd = XG_ERR;
        dec_rxc = '1;
        dec_bad = 1'b0;
        if (!rx_block_lock) begin
            dec_bad = 1'b0;
        end else if (serdes_rx_hdr == SYNC_DATA) begin
            dec_rxd = rx_payload;
            dec_rxc = '0;
        end else if (serdes_rx_hdr == SYNC_CTRL && rx_payload == BLK_IDLE) begin
            dec_rxd = XG_IDLE;
        end else if (!(serdes_rx_hdr == SYNC_CTRL && rx_payload == BLK_ERR)) begin
            dec_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            xgmii_rxd    <= XG_IDLE;
            xgmii_rxc    <= '1;
            rx_bad_block <= 1'b0;
        end else begin
            xgmii_rxd    <= dec_rxd;
            xgmii_rxc    <= dec_rxc;
            rx_bad_block <= dec_bad;
        end
    end

    // ---------------- Frame sync ----------------
    state_t            state_q, state_d;
    logic [5:0]        sh_count_q, sh_count_d;
    logic [4:0]        sh_inv_q, sh_inv_d;
    logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
    logic [6:0]        err_cnt_q, err_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_UNLOCKED;
            sh_count_q <= '0;
            sh_inv_q   <= '0;
            slip_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sh_count_q <= sh_count_d;
            sh_inv_q   <= sh_inv_d;
            slip_cnt_q <= slip_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        sh_count_d        = sh_count_q;
        sh_inv_d          = sh_inv_q;
        slip_cnt_d        = slip_cnt_q;
        err_cnt_d         = err_cnt_q;
        serdes_rx_bitslip = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (!hdr_valid) begin
                    sh_count_d = '0;
                    sh_inv_d   = '0;
                    slip_cnt_d = '0;
                    state_d    = ST_SLIP;
                end else if (sh_count_q == 6'd63) begin
                    sh_count_d = '0;
                    sh_inv_d   = '0;
                    state_d    = ST_LOCKED;
                end else begin
                    sh_count_d = sh_count_q + 6'd1;
                end
            end
            ST_SLIP: begin
                serdes_rx_bitslip = (slip_cnt_q < SLIP_HIGH);
                if (slip_cnt_q == SLIP_LAST) begin
                    slip_cnt_d = '0;
                    state_d    = ST_UNLOCKED;
                end else begin
                    slip_cnt_d = slip_cnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!hdr_valid && err_cnt_q != 7'd127) begin
                    err_cnt_d = err_cnt_q + 7'd1;
                end
                if (!hdr_valid && sh_inv_q == 5'd15) begin
                    sh_count_d = '0;
                    sh_inv_d   = '0;
                    slip_cnt_d = '0;
                    state_d    = ST_SLIP;
                end else begin
                    if (!hdr_valid) begin
                        sh_inv_d = sh_inv_q + 5'd1;
                    end
                    // Window end wins over the increment above.
                    if (sh_count_q == 6'd63) begin
                        sh_count_d = '0;
                        sh_inv_d   = '0;
                    end else begin
                        sh_count_d = sh_count_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    assign rx_block_lock  = (state_q == ST_LOCKED);
    assign rx_error_count = err_cnt_q;

    // ---------------- BER monitor ----------------
    logic [TIMER_W-1:0] timer_q;
    logic [4:0]         ber_q, ber_inc;

    always_comb begin
        ber_inc = ber_q;
        if (!hdr_valid && ber_q != 5'd16) begin
            ber_inc = ber_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_q     <= '0;
            ber_q       <= '0;
            rx_high_ber <= 1'b0;
        end else if (state_q != ST_LOCKED) begin
            timer_q <= '0;
            ber_q   <= '0;
        end else begin
            if (ber_inc == 5'd16) begin
                rx_high_ber <= 1'b1;
            end
            if (timer_q == TIMER_END) begin
                timer_q <= '0;
                ber_q   <= '0;
                if (ber_inc < 5'd16) begin
                    rx_high_ber <= 1'b0;
                end
            end else begin
                timer_q <= timer_q + 1'b1;
                ber_q   <= ber_inc;
            end
        end
    end

    assign rx_status = rx_block_lock & ~rx_high_ber;

endmodule

// File: tb/tb_eth_phy_10g.sv
// Self-checking bench for eth_phy_10g: TX loopback into RX with header corruption injection.
module tb_eth_phy_10g;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic [63:0] serdes_tx_data;
    logic [1:0]  serdes_tx_hdr;
    logic        serdes_rx_bitslip;
    logic        tx_bad_block;
    logic        rx_bad_block;
    logic [6:0]  rx_error_count;
    logic        rx_block_lock;
    logic        rx_high_ber;
    logic        rx_status;

    logic [63:0] lb_data = '0;
    logic [1:0]  lb_hdr  = 2'b10;
    logic        corrupt = 1'b0;

    eth_phy_10g #(
        .DATA_WIDTH(64),
        .CTRL_WIDTH(8),
        .HDR_WIDTH(2),
        .BITSLIP_HIGH_CYCLES(1),
        .BITSLIP_LOW_CYCLES(8),
        .COUNT_125US(125)
    ) dut (
        .clk(clk),
        .rst(rst),
        .xgmii_txd(xgmii_txd),
        .xgmii_txc(xgmii_txc),
        .xgmii_rxd(xgmii_rxd),
        .xgmii_rxc(xgmii_rxc),
        .serdes_tx_data(serdes_tx_data),
        .serdes_tx_hdr(serdes_tx_hdr),
        .serdes_rx_data(lb_data),
        .serdes_rx_hdr(lb_hdr),
        .serdes_rx_bitslip(serdes_rx_bitslip),
        .tx_bad_block(tx_bad_block),
        .rx_bad_block(rx_bad_block),
        .rx_error_count(rx_error_count),
        .rx_block_lock(rx_block_lock),
        .rx_high_ber(rx_high_ber),
        .rx_status(rx_status)
    );

    always #5 clk = ~clk;

    // Gearbox stand-in: one register stage, header can be forced to 00.
    always @(posedge clk) begin
        lb_data <= serdes_tx_data;
        lb_hdr  <= corrupt ? 2'b00 : serdes_tx_hdr;
    end

    localparam logic [63:0] ERR_BLK = 64'h3C78F1E3C78F1E1E;
    localparam logic [63:0] XG_IDLE = 64'h0707070707070707;
    localparam logic [63:0] XG_ERR  = 64'hFEFEFEFEFEFEFEFE;

    typedef struct {
        logic [63:0] txd;
        logic [7:0]  txc;
        logic [1:0]  hdr;
        logic [63:0] data;
        logic        bad;
        logic [63:0] rxd;
        logic [7:0]  rxc;
    } vec_t;

    vec_t        vecs[8];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          locked_cycles = 0;
    int          slip_cycles = 0;
    logic [63:0] d1, d2, d3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rx_block_lock) locked_cycles++;
        if (serdes_rx_bitslip) slip_cycles++;
    endtask

    task automatic drive_rand();
        d3 = d2;
        d2 = d1;
        d1 = {$urandom(), $urandom()};
        xgmii_txd = d1;
        xgmii_txc = 8'h00;
    endtask

    initial begin
        int n, rel, cnt, drop_k;
        logic found, slip_at_drop, ber_at_drop;

        vecs[0] = '{64'h0123456789ABCDEF, 8'h00, 2'b01, 64'h0123456789ABCDEF, 1'b0, 64'h0123456789ABCDEF, 8'h00};
        vecs[1] = '{XG_IDLE,              8'hFF, 2'b10, 64'h000000000000001E, 1'b0, XG_IDLE,              8'hFF};
        vecs[2] = '{XG_ERR,               8'hFF, 2'b10, ERR_BLK,              1'b0, XG_ERR,               8'hFF};
        vecs[3] = '{XG_IDLE,              8'h01, 2'b10, ERR_BLK,              1'b1, XG_ERR,               8'hFF};
        vecs[4] = '{64'h07070707070707FE, 8'hFF, 2'b10, ERR_BLK,              1'b1, XG_ERR,               8'hFF};
        vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 8'h00, 2'b01, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 8'h00};
        vecs[6] = '{64'h0000000000000000, 8'h80, 2'b10, ERR_BLK,              1'b1, XG_ERR,               8'hFF};
        vecs[7] = '{XG_IDLE,              8'hFE, 2'b10, ERR_BLK,              1'b1, XG_ERR,               8'hFF};

        rst = 1'b0;
        xgmii_txd = '0;
        xgmii_txc = '0;
        d1 = '0; d2 = '0; d3 = '0;
        repeat (10) tick();
        chk("rst_tx_data", serdes_tx_data, 64'h0);
        chk("rst_tx_hdr", serdes_tx_hdr, 2'b10);
        chk("rst_rxd", xgmii_rxd, XG_IDLE);
        chk("rst_rxc", xgmii_rxc, 8'hFF);
        chk("rst_bitslip_count", slip_cycles, 0);
        chk("rst_tx_bad", tx_bad_block, 1'b0);
        chk("rst_rx_bad", rx_bad_block, 1'b0);
        chk("rst_err_count", rx_error_count, 7'd0);
        chk("rst_lock", rx_block_lock, 1'b0);
        chk("rst_high_ber", rx_high_ber, 1'b0);
        chk("rst_status", rx_status, 1'b0);

        // Lock acquisition over clean loopback
        rst = 1'b1;
        drive_rand();
        for (n = 1; n <= 200; n++) begin
            tick();
            if (rx_block_lock) break;
            drive_rand();
        end
        chk("lock_acquire_hdrs", n, 64);

        repeat (32) begin
            drive_rand();
            tick();
            chk("loopback_rxd", xgmii_rxd, d3);
        end
        chk("loopback_rxc", xgmii_rxc, 8'h00);
        chk("loopback_status", rx_status, 1'b1);
        chk("loopback_err_count", rx_error_count, 7'd0);

        // Encode/decode table through the loopback
        for (int i = 0; i < 8; i++) begin
            xgmii_txd = vecs[i].txd;
            xgmii_txc = vecs[i].txc;
            tick();
            chk($sformatf("vec%0d_tx_hdr", i), serdes_tx_hdr, vecs[i].hdr);
            chk($sformatf("vec%0d_tx_bad", i), tx_bad_block, vecs[i].bad);
`ifndef ETH_PHY_SCRAMBLER_EN
            chk($sformatf("vec%0d_tx_data", i), serdes_tx_data, vecs[i].data);
`endif
            drive_rand();
            tick();
            chk($sformatf("vec%0d_tx_bad_pulse_end", i), tx_bad_block, 1'b0);
            tick();
            chk($sformatf("vec%0d_rxd", i), xgmii_rxd, vecs[i].rxd);
            chk($sformatf("vec%0d_rxc", i), xgmii_rxc, vecs[i].rxc);
            chk($sformatf("vec%0d_rx_bad", i), rx_bad_block, 1'b0);
        end

        // Light corruption: isolated invalid headers
        for (int k = 0; k < 6; k++) begin
            repeat (998) begin
                drive_rand();
                tick();
            end
            corrupt = 1'b1;
            tick();
            corrupt = 1'b0;
            tick();
            chk("light_rx_bad", rx_bad_block, 1'b1);
            chk("light_rxd", xgmii_rxd, XG_ERR);
            chk("light_rxc", xgmii_rxc, 8'hFF);
            tick();
            chk("light_rx_bad_pulse_end", rx_bad_block, 1'b0);
        end
        chk("light_err_count", rx_error_count, 7'd6);
        chk("light_lock_held", rx_block_lock, 1'b1);
        chk("light_high_ber", rx_high_ber, 1'b0);

        // Strong corruption: start the burst early in both the header window and BER window
        found = 1'b0;
        for (int w = 0; w < 9000; w++) begin
            if ((locked_cycles % 64) < 8 && (locked_cycles % 125) < 8) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("burst_align_found", found, 1'b1);

        slip_cycles  = 0;
        drop_k       = 0;
        slip_at_drop = 1'b0;
        ber_at_drop  = 1'b0;
        corrupt      = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (drop_k == 0 && !rx_block_lock) begin
                drop_k       = k;
                slip_at_drop = serdes_rx_bitslip;
                ber_at_drop  = rx_high_ber;
            end
        end
        corrupt = 1'b0;
        chk("lock_drop_invalid_hdrs", drop_k - 1, 16);
        chk("bitslip_at_drop", slip_at_drop, 1'b1);
        chk("high_ber_at_drop", ber_at_drop, 1'b1);

        rel = 20 - drop_k;
        for (int w = 0; w < 300; w++) begin
            tick();
            rel++;
            if (rx_block_lock) break;
        end
        chk("relock_cycles", rel, 73);
        chk("bitslip_high_cycles", slip_cycles, 1);
        chk("burst_err_count", rx_error_count, 7'd22);
        chk("high_ber_at_relock", rx_high_ber, 1'b1);
        chk("status_at_relock", rx_status, 1'b0);

        cnt = 0;
        for (int w = 0; w < 300; w++) begin
            tick();
            cnt++;
            if (!rx_high_ber) break;
        end
        chk("high_ber_clear_cycles", cnt, 125);
        chk("final_status", rx_status, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
